ysyx_220053_if_id_queue: RTL

//  Instruction queue between fetch and decode. Buffers {pc, instr} pairs from
//  the fetch stage and decouples fetch from decode stalls.

---
 rtl/ysyx_220053_if_id_queue_pkg.sv | 9 +
 rtl/ysyx_220053_ifq_ram.sv | 23 ++
 rtl/ysyx_220053_if_id_queue.sv | 87 ++++++++
 3 files changed

// File: rtl/ysyx_220053_if_id_queue_pkg.sv
// Shared widths and constants for the fetch-to-decode instruction queue.
// RESET_PC is the boot address that fetch starts from after reset.
package ysyx_220053_if_id_queue_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_220053_ifq_ram.sv
// Entry storage for the instruction queue.
// It has one synchronous write port and one asynchronous read port, and the array is never reset.
module ysyx_220053_ifq_ram #(
  parameter int DEPTH = 2,
  parameter int W     = 96
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_220053_if_id_queue.sv
// Instruction queue between fetch and decode. It holds {pc, instr} pairs and is emptied by a redirect flush.
// Handshake: a side transfers at the posedge when its valid and ready are both high; out_valid/in_ready never depend on the opposite side.
module ysyx_220053_if_id_queue
  import ysyx_220053_if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XW    = XLEN,
  parameter int IW    = ILEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XW-1:0]              in_pc,
  input  logic [IW-1:0]              in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XW-1:0]              out_pc,
  output logic [IW-1:0]              out_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  // The pointer MSB is a wrap bit, so equal slots mean full when the laps differ.
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign in_ready  = !rst && (r_count != PW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  ysyx_220053_ifq_ram #(
    .DEPTH (DEPTH),
    .W     (XW + IW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push && !flush),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata ({in_pc, in_instr}),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata ({out_pc, out_instr})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Drop everything, including any same-cycle push or pop.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && r_count == PW'(DEPTH))) else $error("push while full");
      assert (!(w_pop && r_count == '0)) else $error("pop while empty");
      assert (r_count == PW'(r_wr_ptr - r_rd_ptr)) else $error("count/pointer disagreement");
      assert (w_full == (r_count == PW'(DEPTH))) else $error("full flag disagreement");
      assert (w_empty == (r_count == '0)) else $error("empty flag disagreement");
    end
  end

endmodule
